pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg.sv | 60 ++++++
 rtl/pipe_stage_chain.sv | 117 +++++++++++
 tb/tb_pipe_stage_chain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipe_stage_chain slice.
//   PIPE_MAX_DEPTH : largest supported number of pipeline stages.
//   stage_idx_t    : 3-bit stage index / small per-cycle stage count.
//   sat_add32      : 32-bit add that sticks at all-ones instead of wrapping.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    typedef logic [2:0] stage_idx_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg -- one pipeline stage register (payload + valid bit).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load             : capture next_data / next_valid this edge
//   bubble           : stage advances but receives nothing (valid cleared)
//   flush            : kill this stage's valid bit (wins over bubble/hold/load)
//   next_data/valid  : incoming entry from the younger stage (or pipe input)
//   data, valid      : registered stage contents
// load and bubble are never asserted together by the chain.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bubble,
    input  logic             flush,
    input  logic [WIDTH-1:0] next_data,
    input  logic             next_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Payload: follows the load path only; flush and bubble leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= next_data;
        end else begin
            data_r <= data_r;
        end
    end

    // Valid bit: flush first, then load, then bubble, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= next_valid;
        end else if (bubble) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain -- DEPTH-stage pipeline with per-stage stall and flush.
// Stage 0 is youngest, stage DEPTH-1 oldest; the oldest stage is consumed
// every cycle it is not held (no output handshake).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : entry offered to stage 0
//   in_data      : payload offered to stage 0
//   in_ready     : stage 0 accepts this cycle (combinational, = !hold[0])
//   stall        : per-stage hold request; a hold freezes every younger stage
//   flush        : per-stage kill of the valid bit; never affects the holds
//   stage_valid  : valid bit of each stage
//   stage_data   : stage i payload at [i*WIDTH +: WIDTH]
// Optional (macro PIPE_STAGE_CHAIN_PERF_EN):
//   stall_cycles : cycles with stage 0 held, saturating
//   bubble_count : bubbles inserted, saturating
// -----------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            bubble_count
`endif
);

    // hold_s[i] = stall[i] | hold_s[i+1], written as an OR over stall[DEPTH-1:i]
    // so the chain has no combinational self-reference.
    logic [DEPTH:0]   hold_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] bubble_s;

    // Hold chain: an older stage's stall propagates to all younger stages.
    always_comb begin
        hold_s        = {(DEPTH+1){1'b0}};
        hold_s[DEPTH] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hold_s[i] = |(stall >> i);
        end
    end

    assign in_ready = ~hold_s[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] next_data_s;
        logic             next_valid_s;

        if (i == 0) begin : g_head
            assign load_s[i]    = ~hold_s[0];
            assign bubble_s[i]  = 1'b0;
            assign next_data_s  = in_data;
            assign next_valid_s = in_valid;
        end else begin : g_body
            // Free stage behind a held one receives a bubble instead of data.
            assign load_s[i]    = ~hold_s[i] & ~hold_s[i-1];
            assign bubble_s[i]  = ~hold_s[i] &  hold_s[i-1];
            assign next_data_s  = stage_data[(i-1)*WIDTH +: WIDTH];
            assign next_valid_s = stage_valid[i-1];
        end

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (load_s[i]),
            .bubble     (bubble_s[i]),
            .flush      (flush[i]),
            .next_data  (next_data_s),
            .next_valid (next_valid_s),
            .data       (stage_data[i*WIDTH +: WIDTH]),
            .valid      (stage_valid[i])
        );
    end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    stage_idx_t  bubbles_s;
    logic [31:0] stall_cycles_r;
    logic [31:0] bubble_count_r;

    // Number of bubbles inserted this cycle (at most DEPTH-1 <= 7).
    always_comb begin
        bubbles_s = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            bubbles_s = bubbles_s + {2'b00, bubble_s[i]};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
            bubble_count_r <= 32'h0000_0000;
        end else begin
            stall_cycles_r <= sat_add32(stall_cycles_r, {31'b0, hold_s[0]});
            bubble_count_r <= sat_add32(bubble_count_r, {29'b0, bubbles_s});
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign bubble_count = bubble_count_r;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain -- directed self-checking bench for pipe_stage_chain
// (WIDTH=32, DEPTH=4). Performance-counter checks are compiled in only when
// PIPE_STAGE_CHAIN_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0]            stall_cycles;
    logic [31:0]            bubble_count;
`endif

    int checks;
    int failures;

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sd(input int i);
        return stage_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = base + k;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; stall = 4'b0000; flush = 4'b0000;
        #12;
        checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", stage_valid, 4'b0000); end
        checks++; if (stage_data !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", stage_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        checks++; if (stall_cycles !== 32'h0 || bubble_count !== 32'h0) begin failures++; $display("FAIL reset_perf got=%h/%h exp=0/0", stall_cycles, bubble_count); end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_streaming();
        in_valid = 1'b1; in_data = 32'h10; tick();
        checks++; if (sd(0) !== 32'h10 || stage_valid[0] !== 1'b1) begin failures++; $display("FAIL stream_s0 got=%h/%b exp=10/1", sd(0), stage_valid[0]); end
        in_data = 32'h20; tick();
        in_data = 32'h30; tick();
        in_data = 32'h40; tick();
        checks++; if (sd(3) !== 32'h10 || stage_valid !== 4'b1111) begin failures++; $display("FAIL stream_first_out got=%h/%b exp=10/1111", sd(3), stage_valid); end
        in_valid = 1'b0; in_data = 32'h0;
        tick(); tick(); tick();
        checks++; if (sd(3) !== 32'h40) begin failures++; $display("FAIL stream_last_out got=%h exp=40", sd(3)); end
        checks++; if (stage_valid !== 4'b1000) begin failures++; $display("FAIL stream_drain_valid got=%b exp=1000", stage_valid); end
    endtask

    task automatic test_stall();
        fill(32'hA1);
        stall = 4'b0100; in_valid = 1'b1; in_data = 32'hA5;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (stage_valid !== 4'b0111) begin failures++; $display("FAIL stall_valid got=%b exp=0111", stage_valid); end
        checks++; if (sd(0) !== 32'hA4 || sd(1) !== 32'hA3 || sd(2) !== 32'hA2) begin failures++; $display("FAIL stall_hold got=%h,%h,%h exp=a4,a3,a2", sd(0), sd(1), sd(2)); end
        checks++; if (sd(3) !== 32'hA1) begin failures++; $display("FAIL stall_bubble_data got=%h exp=a1", sd(3)); end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        checks++; if (bubble_count !== 32'd1) begin failures++; $display("FAIL stall_bubble_count got=%0d exp=1", bubble_count); end
        checks++; if (stall_cycles !== 32'd1) begin failures++; $display("FAIL stall_cycles got=%0d exp=1", stall_cycles); end
`endif
        stall = 4'b0000; in_valid = 1'b0; in_data = 32'h0;
        tick();
        checks++; if (sd(3) !== 32'hA2 || stage_valid[3] !== 1'b1) begin failures++; $display("FAIL stall_resume got=%h/%b exp=a2/1", sd(3), stage_valid[3]); end
    endtask

    task automatic test_flush_over_stall();
        fill(32'hC1);
        stall = 4'b0010; flush = 4'b0010; in_valid = 1'b1; in_data = 32'hC5;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (stage_valid !== 4'b1001) begin failures++; $display("FAIL flush_stall_valid got=%b exp=1001", stage_valid); end
        checks++; if (sd(1) !== 32'hC3 || sd(0) !== 32'hC4 || sd(3) !== 32'hC2) begin failures++; $display("FAIL flush_stall_data got=%h,%h,%h exp=c4,c3,c2", sd(0), sd(1), sd(3)); end
        stall = 4'b0000; flush = 4'b0001; in_data = 32'hC6;
        tick();
        checks++; if (stage_valid !== 4'b0010) begin failures++; $display("FAIL flush_load_valid got=%b exp=0010", stage_valid); end
        checks++; if (sd(0) !== 32'hC6 || sd(1) !== 32'hC4) begin failures++; $display("FAIL flush_load_data got=%h,%h exp=c6,c4", sd(0), sd(1)); end
        flush = 4'b0000; in_valid = 1'b0; in_data = 32'h0;
    endtask

    task automatic test_async_reset();
        fill(32'hE1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL async_rst_valid got=%b exp=0000", stage_valid); end
        checks++; if (stage_data !== 128'h0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", stage_data); end
        #1;
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hD1;
        tick();
        checks++; if (stage_valid !== 4'b0001 || sd(0) !== 32'hD1) begin failures++; $display("FAIL async_rst_first_load got=%b/%h exp=0001/d1", stage_valid, sd(0)); end
        in_valid = 1'b0; in_data = 32'h0;
    endtask

    task automatic test_dropped_input();
        bit seen;
        stall = 4'b0001; in_valid = 1'b1; in_data = 32'hAB;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL drop_in_ready got=%b exp=0", in_ready); end
        tick(); tick();
        checks++; if (sd(0) !== 32'hD1 || stage_valid[0] !== 1'b1) begin failures++; $display("FAIL drop_hold got=%h/%b exp=d1/1", sd(0), stage_valid[0]); end
        stall = 4'b0000; in_valid = 1'b0; in_data = 32'h0;
        seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            for (int s = 0; s < DEPTH; s++) begin
                if (sd(s) === 32'hAB) seen = 1'b1;
            end
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL drop_never_seen got=%b exp=0", seen); end
        checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL drop_drained got=%b exp=0000", stage_valid); end
    endtask

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    task automatic test_saturation();
        force dut.stall_cycles_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_r;
        stall = 4'b0001;
        tick(); tick(); tick();
        checks++; if (stall_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stall_saturate got=%h exp=ffffffff", stall_cycles); end
        stall = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush_over_stall();
        test_async_reset();
        test_dropped_input();
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        test_saturation();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
